fe_capture_ctrl: RTL and testbench

Capture sequencer for the USB front-end capture path, in the `fe_clk` domain. It converts the software arm level and pattern-match pulses into the `I_capture_enable` and FIFO-flush controls that gate `fe_capture`. It applies a programmable trigger delay, counts FIFO writes against the capture length, and reports done, overflow and triggered status back to the register block.

---
 rtl/fe_capture_ctrl_pkg.sv | 27 ++
 rtl/fe_trigger_delay.sv | 36 +++
 rtl/fe_capture_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_fe_capture_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fe_capture_ctrl_pkg.sv
// Shared state encodings and helpers for the front-end capture sequencer.
package fe_capture_ctrl_pkg;

  localparam int FE_CTRL_STATE_W = 3;

  typedef enum logic [FE_CTRL_STATE_W-1:0] {
    FE_CTRL_S_IDLE       = 3'd0,
    FE_CTRL_S_WAIT_MATCH = 3'd1,
    FE_CTRL_S_DELAY      = 3'd2,
    FE_CTRL_S_CAPTURE    = 3'd3,
    FE_CTRL_S_DONE       = 3'd4
  } fe_ctrl_state_e;

  // Map any unused encoding onto IDLE so status never reports a bogus state.
  function automatic fe_ctrl_state_e fe_ctrl_decode(input logic [FE_CTRL_STATE_W-1:0] code);
    fe_ctrl_state_e result;
    case (code)
      3'd1:    result = FE_CTRL_S_WAIT_MATCH;
      3'd2:    result = FE_CTRL_S_DELAY;
      3'd3:    result = FE_CTRL_S_CAPTURE;
      3'd4:    result = FE_CTRL_S_DONE;
      default: result = FE_CTRL_S_IDLE;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/fe_trigger_delay.sv
// Loadable down-counter that times the gap between trigger and capture start.
// It stops at zero; the zero flag tells the sequencer the delay has expired.
module fe_trigger_delay #(
  parameter int pDELAY_WIDTH = 20
) (
  input  logic                    fe_clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic [pDELAY_WIDTH-1:0] i_load_val,
  input  logic                    i_en,
  output logic [pDELAY_WIDTH-1:0] o_value,
  output logic                    o_zero
);

  localparam logic [pDELAY_WIDTH-1:0] DLY_ZERO = {pDELAY_WIDTH{1'b0}};
  localparam logic [pDELAY_WIDTH-1:0] DLY_ONE  = {{(pDELAY_WIDTH-1){1'b0}}, 1'b1};

  logic [pDELAY_WIDTH-1:0] r_count;

  // Load takes priority; otherwise count down while enabled, holding at zero.
  always_ff @(posedge fe_clk or posedge rst) begin
    if (rst) begin
      r_count <= DLY_ZERO;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != DLY_ZERO)) begin
      r_count <= r_count - DLY_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_value = r_count;
  assign o_zero  = (r_count == DLY_ZERO);

endmodule

// File: rtl/fe_capture_ctrl.sv
// Capture sequencer for the front-end capture path: turns the software arm
// level and pattern-match pulses into capture-enable / FIFO-flush controls,
// applies the trigger delay, counts FIFO writes and reports status.
module fe_capture_ctrl
  import fe_capture_ctrl_pkg::*;
#(
  parameter int pLEN_WIDTH   = 16,
  parameter int pDELAY_WIDTH = 20
) (
  input  logic                       fe_clk,
  input  logic                       reset_i,
  input  logic                       I_arm,
  input  logic                       I_trigger_mode,
  input  logic                       I_match,
  input  logic [pDELAY_WIDTH-1:0]    I_trigger_delay,
  input  logic [pLEN_WIDTH-1:0]      I_capture_len,
  input  logic                       I_data_wr,
  input  logic                       I_fifo_full,
  output logic                       O_capture_enable,
  output logic                       O_fifo_flush,
  output logic [FE_CTRL_STATE_W-1:0] O_state,
  output logic                       O_triggered,
  output logic                       O_done,
  output logic                       O_overflow,
  output logic [pLEN_WIDTH-1:0]      O_entry_count
);

  localparam logic [pLEN_WIDTH-1:0]   LEN_ZERO = {pLEN_WIDTH{1'b0}};
  localparam logic [pLEN_WIDTH-1:0]   LEN_ONE  = {{(pLEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pLEN_WIDTH-1:0]   LEN_MAX  = {pLEN_WIDTH{1'b1}};
  localparam logic [pDELAY_WIDTH-1:0] DLY_ZERO = {pDELAY_WIDTH{1'b0}};
  localparam logic [pDELAY_WIDTH-1:0] DLY_ONE  = {{(pDELAY_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]              r_rst_pipe;
  logic                    w_rst;
  logic                    r_arm_d;
  fe_ctrl_state_e          r_state;
  logic                    r_flush;
  logic                    r_triggered;
  logic                    r_overflow;
  logic [pLEN_WIDTH-1:0]   r_count;

  logic                    w_arm_edge;
  logic                    w_len_zero;
  logic                    w_delay_cfg_zero;
  logic [pLEN_WIDTH:0]     w_len_sum;
  logic                    w_len_reached;
  logic [pLEN_WIDTH-1:0]   w_count_inc;
  logic                    w_trig;
  logic                    w_dly_load;
  logic [pDELAY_WIDTH-1:0] w_dly_load_val;
  logic                    w_dly_en;
  logic                    w_dly_zero;
  logic [pDELAY_WIDTH-1:0] w_unused_dly_value;

  // Reset asserts immediately but is released only on a clock edge, two flops deep.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_rst_pipe <= 2'b11;
    end else begin
      r_rst_pipe <= {r_rst_pipe[0], 1'b0};
    end
  end

  assign w_rst = r_rst_pipe[1];

  assign w_arm_edge       = I_arm & ~r_arm_d;
  assign w_len_zero       = (I_capture_len == LEN_ZERO);
  assign w_delay_cfg_zero = (I_trigger_delay == DLY_ZERO);
  // The write arriving this cycle counts toward the length, so stop on it.
  assign w_len_sum        = {1'b0, r_count} + {{pLEN_WIDTH{1'b0}}, I_data_wr};
  assign w_len_reached    = (w_len_sum >= {1'b0, I_capture_len});
  assign w_dly_load_val   = I_trigger_delay - DLY_ONE;
  assign w_dly_load       = w_trig & ~w_delay_cfg_zero;
  assign w_dly_en         = (r_state == FE_CTRL_S_DELAY);

  // Saturating write counter increment; writes count in every state.
  always_comb begin
    w_count_inc = r_count;
    if (I_data_wr && (r_count != LEN_MAX)) begin
      w_count_inc = r_count + LEN_ONE;
    end else begin
      w_count_inc = r_count;
    end
  end

  // Trigger event: immediate on arm in mode 0, or a match while waiting in mode 1.
  always_comb begin
    w_trig = 1'b0;
    case (r_state)
      FE_CTRL_S_IDLE, FE_CTRL_S_DONE: begin
        if (w_arm_edge && !w_len_zero && !I_trigger_mode) begin
          w_trig = 1'b1;
        end else begin
          w_trig = 1'b0;
        end
      end
      FE_CTRL_S_WAIT_MATCH: begin
        if (I_arm && I_match) begin
          w_trig = 1'b1;
        end else begin
          w_trig = 1'b0;
        end
      end
      default: w_trig = 1'b0;
    endcase
  end

  fe_trigger_delay #(
    .pDELAY_WIDTH (pDELAY_WIDTH)
  ) u_trigger_delay (
    .fe_clk     (fe_clk),
    .rst        (w_rst),
    .i_load     (w_dly_load),
    .i_load_val (w_dly_load_val),
    .i_en       (w_dly_en),
    .o_value    (w_unused_dly_value),
    .o_zero     (w_dly_zero)
  );

  // Sequencer FSM with its sticky status flags, flush pulse and entry counter.
  always_ff @(posedge fe_clk or posedge w_rst) begin
    if (w_rst) begin
      r_arm_d     <= 1'b0;
      r_state     <= FE_CTRL_S_IDLE;
      r_flush     <= 1'b0;
      r_triggered <= 1'b0;
      r_overflow  <= 1'b0;
      r_count     <= LEN_ZERO;
    end else begin
      r_arm_d <= I_arm;
      r_flush <= 1'b0;
      r_count <= w_count_inc;
      case (r_state)
        FE_CTRL_S_IDLE, FE_CTRL_S_DONE: begin
          if (w_arm_edge) begin
            r_flush     <= 1'b1;
            r_count     <= LEN_ZERO;
            r_triggered <= w_trig;
            r_overflow  <= 1'b0;
            if (w_len_zero) begin
              r_state <= FE_CTRL_S_DONE;
            end else if (I_trigger_mode) begin
              r_state <= FE_CTRL_S_WAIT_MATCH;
            end else if (w_delay_cfg_zero) begin
              r_state <= FE_CTRL_S_CAPTURE;
            end else begin
              r_state <= FE_CTRL_S_DELAY;
            end
          end else if ((r_state == FE_CTRL_S_DONE) && !I_arm) begin
            r_state <= FE_CTRL_S_IDLE;
          end else begin
            r_state <= r_state;
          end
        end
        FE_CTRL_S_WAIT_MATCH: begin
          if (!I_arm) begin
            r_state <= FE_CTRL_S_IDLE;
          end else if (I_match) begin
            r_triggered <= 1'b1;
            r_state     <= w_delay_cfg_zero ? FE_CTRL_S_CAPTURE : FE_CTRL_S_DELAY;
          end else begin
            r_state <= FE_CTRL_S_WAIT_MATCH;
          end
        end
        FE_CTRL_S_DELAY: begin
          if (!I_arm) begin
            r_state <= FE_CTRL_S_IDLE;
          end else if (w_dly_zero) begin
            r_state <= FE_CTRL_S_CAPTURE;
          end else begin
            r_state <= FE_CTRL_S_DELAY;
          end
        end
        FE_CTRL_S_CAPTURE: begin
          if (!I_arm) begin
            r_state <= FE_CTRL_S_IDLE;
          end else if (w_len_reached) begin
            r_state <= FE_CTRL_S_DONE;
          end else if (I_fifo_full) begin
            r_overflow <= 1'b1;
            r_state    <= FE_CTRL_S_DONE;
          end else begin
            r_state <= FE_CTRL_S_CAPTURE;
          end
        end
        default: r_state <= FE_CTRL_S_IDLE;
      endcase
    end
  end

  assign O_state          = fe_ctrl_decode(r_state);
  assign O_capture_enable = (r_state == FE_CTRL_S_CAPTURE);
  assign O_done           = (r_state == FE_CTRL_S_DONE);
  assign O_fifo_flush     = r_flush;
  assign O_triggered      = r_triggered;
  assign O_overflow       = r_overflow;
  assign O_entry_count    = r_count;

endmodule

// File: tb/tb_fe_capture_ctrl.sv
// Directed bench for fe_capture_ctrl: expected outputs are queued when each
// step's stimulus is driven and popped against the DUT after the clock edge.
module tb_fe_capture_ctrl;

  logic        fe_clk = 1'b0;
  logic        reset_i;
  logic        I_arm;
  logic        I_trigger_mode;
  logic        I_match;
  logic [19:0] I_trigger_delay;
  logic [15:0] I_capture_len;
  logic        I_data_wr;
  logic        I_fifo_full;
  logic        O_capture_enable;
  logic        O_fifo_flush;
  logic [2:0]  O_state;
  logic        O_triggered;
  logic        O_done;
  logic        O_overflow;
  logic [15:0] O_entry_count;

  typedef struct {
    string       tag;
    int unsigned exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_run  = 0;
  int       n_fail = 0;

  always #5 fe_clk = ~fe_clk;

  fe_capture_ctrl dut (
    .fe_clk           (fe_clk),
    .reset_i          (reset_i),
    .I_arm            (I_arm),
    .I_trigger_mode   (I_trigger_mode),
    .I_match          (I_match),
    .I_trigger_delay  (I_trigger_delay),
    .I_capture_len    (I_capture_len),
    .I_data_wr        (I_data_wr),
    .I_fifo_full      (I_fifo_full),
    .O_capture_enable (O_capture_enable),
    .O_fifo_flush     (O_fifo_flush),
    .O_state          (O_state),
    .O_triggered      (O_triggered),
    .O_done           (O_done),
    .O_overflow       (O_overflow),
    .O_entry_count    (O_entry_count)
  );

  task automatic push(input string tag, input int unsigned v);
    sb_item_t it;
    it.tag = tag;
    it.exp = v;
    sb_q.push_back(it);
  endtask

  task automatic exp_all(input int unsigned st, input int unsigned en, input int unsigned fl,
                         input int unsigned trg, input int unsigned dn, input int unsigned ov,
                         input int unsigned cnt);
    push("state", st);
    push("enable", en);
    push("flush", fl);
    push("triggered", trg);
    push("done", dn);
    push("overflow", ov);
    push("count", cnt);
  endtask

  task automatic cmp_all(input string step_name);
    int unsigned obs[7];
    obs[0] = {29'd0, O_state};
    obs[1] = {31'd0, O_capture_enable};
    obs[2] = {31'd0, O_fifo_flush};
    obs[3] = {31'd0, O_triggered};
    obs[4] = {31'd0, O_done};
    obs[5] = {31'd0, O_overflow};
    obs[6] = {16'd0, O_entry_count};
    for (int i = 0; i < 7; i++) begin
      sb_item_t it;
      n_run++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $error("FAIL %s: scoreboard empty", step_name);
      end else begin
        it = sb_q.pop_front();
        assert (obs[i] === it.exp)
        else begin
          n_fail++;
          $error("FAIL %s/%s: observed=%0d expected=%0d", step_name, it.tag, obs[i], it.exp);
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge fe_clk);
    @(negedge fe_clk);
  endtask

  task automatic step(input string name, input logic arm, input logic match, input logic wr,
                      input logic full, input int unsigned st, input int unsigned en,
                      input int unsigned fl, input int unsigned trg, input int unsigned dn,
                      input int unsigned ov, input int unsigned cnt);
    I_arm       = arm;
    I_match     = match;
    I_data_wr   = wr;
    I_fifo_full = full;
    exp_all(st, en, fl, trg, dn, ov, cnt);
    cyc();
    cmp_all(name);
  endtask

  initial begin
    reset_i         = 1'b1;
    I_arm           = 1'b0;
    I_trigger_mode  = 1'b0;
    I_match         = 1'b0;
    I_trigger_delay = 20'd0;
    I_capture_len   = 16'd4;
    I_data_wr       = 1'b0;
    I_fifo_full     = 1'b0;
    @(negedge fe_clk);
    @(negedge fe_clk);
    exp_all(0, 0, 0, 0, 0, 0, 0);
    cmp_all("reset");
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) step("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Mode 0, no delay, len 4, one write per cycle, then lag writes.
    step("t1_arm", 1, 0, 0, 0, 3, 1, 1, 1, 0, 0, 0);
    for (int unsigned k = 1; k <= 3; k++) step("t1_wr", 1, 0, 1, 0, 3, 1, 0, 1, 0, 0, k);
    step("t1_last", 1, 0, 1, 0, 4, 0, 0, 1, 1, 0, 4);
    step("t1_lag1", 1, 0, 1, 0, 4, 0, 0, 1, 1, 0, 5);
    step("t1_lag2", 1, 0, 1, 0, 4, 0, 0, 1, 1, 0, 6);
    step("t1_fall", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6);

    // Mode 1, delay 10; match in arm-edge cycle ignored; abort in CAPTURE.
    I_trigger_mode  = 1'b1;
    I_trigger_delay = 20'd10;
    step("t2_arm", 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t2_wait", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("t2_match", 1, 1, 0, 0, 2, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step("t2_delay", 1, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0);
    step("t2_start", 1, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0);
    step("t2_write", 1, 0, 1, 0, 3, 1, 0, 1, 0, 0, 1);
    step("t2_abort", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);

    // FIFO full after 5 of 8 writes.
    I_trigger_mode  = 1'b0;
    I_trigger_delay = 20'd0;
    I_capture_len   = 16'd8;
    step("t3_arm", 1, 0, 0, 0, 3, 1, 1, 1, 0, 0, 0);
    for (int unsigned k = 1; k <= 5; k++) step("t3_wr", 1, 0, 1, 0, 3, 1, 0, 1, 0, 0, k);
    step("t3_full", 1, 0, 0, 1, 4, 0, 0, 1, 1, 1, 5);
    step("t3_fall", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5);

    // Abort during a 100-cycle delay.
    I_trigger_delay = 20'd100;
    I_capture_len   = 16'd4;
    step("t4_arm", 1, 0, 0, 0, 2, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 14; i++) step("t4_delay", 1, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0);
    step("t4_abort", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Zero length: straight to DONE; held arm is not a re-arm; fall+rise clears count.
    I_capture_len = 16'd0;
    for (int unsigned k = 1; k <= 3; k++) step("t5_pre", 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, k);
    step("t5_arm", 1, 0, 0, 0, 4, 0, 1, 0, 1, 0, 0);
    for (int unsigned k = 1; k <= 2; k++) step("t5_late", 1, 0, 1, 0, 4, 0, 0, 0, 1, 0, k);
    step("t5_hold", 1, 0, 0, 0, 4, 0, 0, 0, 1, 0, 2);
    step("t5_fall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step("t5_rearm", 1, 0, 0, 0, 4, 0, 1, 0, 1, 0, 0);
    step("t5_fall2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Delay of 1 and length of 1.
    I_trigger_delay = 20'd1;
    I_capture_len   = 16'd1;
    step("t7_arm", 1, 0, 0, 0, 2, 0, 1, 1, 0, 0, 0);
    step("t7_start", 1, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0);
    step("t7_wr", 1, 0, 1, 0, 4, 0, 0, 1, 1, 0, 1);
    step("t7_fall", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);

    // Asynchronous reset in the middle of CAPTURE, between clock edges.
    I_trigger_delay = 20'd0;
    I_capture_len   = 16'd100;
    step("t6_arm", 1, 0, 0, 0, 3, 1, 1, 1, 0, 0, 0);
    step("t6_wr1", 1, 0, 1, 0, 3, 1, 0, 1, 0, 0, 1);
    step("t6_wr2", 1, 0, 1, 0, 3, 1, 0, 1, 0, 0, 2);
    #2;
    reset_i = 1'b1;
    #1;
    exp_all(0, 0, 0, 0, 0, 0, 0);
    cmp_all("t6_async_rst");
    @(negedge fe_clk);
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) step("t6_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
